// File: rtl/game_control.sv
// game_control: sequencing FSM between board inputs and the drawing datapath.
// Ports: clock/reset, start, frame_tick, btn_*, draw_*_done in; one-hot
//   commands, draw_map/draw_link enables, sticky draw_error, state_dbg out.
module game_control #(
  parameter int ATTACK_FRAMES = 8,
  parameter int DRAW_TIMEOUT  = 100000,
  parameter int TO_W          = 17
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       btn_attack,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       draw_map_done,
  input  logic       draw_link_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       draw_map,
  output logic       draw_link,
  output logic       draw_error,
  output logic [3:0] state_dbg
);

  localparam int CD_W = $clog2(ATTACK_FRAMES + 1);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_DRAW_MAP  = 3'd2;
  localparam logic [2:0] S_DRAW_LINK = 3'd3;
  localparam logic [2:0] S_IDLE      = 3'd4;
  localparam logic [2:0] S_MOVE      = 3'd5;
  localparam logic [2:0] S_ATTACK    = 3'd6;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam logic [TO_W-1:0] WD_LAST =
    TO_W'(DRAW_TIMEOUT - 1);
  localparam logic [CD_W-1:0] CD_LOAD =
    CD_W'(ATTACK_FRAMES);

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [1:0]      dir;
  logic [1:0]      dir_nx;
  logic [1:0]      dir_pick;
  logic [CD_W-1:0] cooldown;
  logic [TO_W-1:0] wd;
  logic            frame_pending;
  logic            set_err;

  logic in_draw;
  logic first_cyc;
  logic done_sel;
  logic done_ok;
  logic timeout;
  logic decide;
  logic atk_ok;
  logic any_dir;

  assign in_draw = (state == S_DRAW_MAP) ||
                   (state == S_DRAW_LINK);

  // The watchdog is zero only in the entry cycle of
  // a draw state, so it doubles as the stale-done mask.
  assign first_cyc = (wd == '0);

  assign done_sel = (state == S_DRAW_MAP) ?
                    draw_map_done : draw_link_done;

  assign done_ok = in_draw && !first_cyc && done_sel;
  assign timeout = in_draw && (wd == WD_LAST);

  assign decide = (state == S_IDLE) &&
                  (frame_tick || frame_pending);

  assign atk_ok  = btn_attack && (cooldown == '0);
  assign any_dir = btn_up || btn_down ||
                   btn_left || btn_right;

  always_comb begin
    dir_pick = D_RIGHT;
    if (btn_up) begin
      dir_pick = D_UP;
    end else if (btn_down) begin
      dir_pick = D_DOWN;
    end else if (btn_left) begin
      dir_pick = D_LEFT;
    end
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    set_err  = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (start) begin
          state_nx = S_INIT;
        end
      end
      S_INIT: begin
        state_nx = S_DRAW_MAP;
      end
      S_DRAW_MAP: begin
        // done beats a simultaneous timeout
        if (done_ok) begin
          state_nx = S_DRAW_LINK;
        end else if (timeout) begin
          state_nx = S_IDLE;
          set_err  = 1'b1;
        end
      end
      S_DRAW_LINK: begin
        if (done_ok) begin
          state_nx = S_IDLE;
        end else if (timeout) begin
          state_nx = S_IDLE;
          set_err  = 1'b1;
        end
      end
      S_IDLE: begin
        if (decide) begin
          if (atk_ok) begin
            state_nx = S_ATTACK;
          end else if (any_dir) begin
            state_nx = S_MOVE;
            dir_nx   = dir_pick;
          end
        end
      end
      S_MOVE: begin
        state_nx = S_DRAW_MAP;
      end
      S_ATTACK: begin
        state_nx = S_DRAW_MAP;
      end
      default: begin
        state_nx = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_WAIT;
      dir   <= D_UP;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
    end
  end

  // Cleared on any state change, so it restarts at
  // zero on entry to each draw state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd <= '0;
    end else if (state_nx != state) begin
      wd <= '0;
    end else if (in_draw) begin
      wd <= wd + 1'b1;
    end
  end

  // Ticks arriving while busy fold into one pending
  // decision; any idle cycle consumes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_pending <= 1'b0;
    end else if (state == S_IDLE) begin
      frame_pending <= 1'b0;
    end else if (frame_tick) begin
      frame_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cooldown <= '0;
    end else if (state == S_ATTACK) begin
      cooldown <= CD_LOAD;
    end else if (frame_tick && cooldown != '0) begin
      cooldown <= cooldown - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      draw_error <= 1'b0;
    end else if (set_err) begin
      draw_error <= 1'b1;
    end
  end

  assign init      = (state == S_INIT);
  assign idle      = (state == S_IDLE);
  assign attack    = (state == S_ATTACK);
  assign draw_map  = (state == S_DRAW_MAP);
  assign draw_link = (state == S_DRAW_LINK);

  assign up    = (state == S_MOVE) && (dir == D_UP);
  assign down  = (state == S_MOVE) && (dir == D_DOWN);
  assign left  = (state == S_MOVE) && (dir == D_LEFT);
  assign right = (state == S_MOVE) && (dir == D_RIGHT);

  assign state_dbg = {1'b0, state};

endmodule
